// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, parameter defaults and grant encoding for the RF write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int RF_AW            = 5;
  localparam int RF_DW            = 32;
  localparam int WBARB_LDQ_DEPTH  = 4;
  localparam int WBARB_STARVE_LIM = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_PIPE = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester/RF-side bundle of the write-port arbiter; slave = arbiter, master = environment.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) ();

  logic          pipe_valid;
  logic          pipe_ready;
  logic [AW-1:0] pipe_wR;
  logic [DW-1:0] pipe_wD;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_wR;
  logic [DW-1:0] ld_wD;
  logic          rf_we;
  logic [AW-1:0] rf_wR;
  logic [DW-1:0] rf_wD;
  logic          ldq_empty;

  modport slave (
    input  pipe_valid, pipe_wR, pipe_wD, ld_valid, ld_wR, ld_wD,
    output pipe_ready, ld_ready, rf_we, rf_wR, rf_wD, ldq_empty
  );

  modport master (
    output pipe_valid, pipe_wR, pipe_wD, ld_valid, ld_wR, ld_wD,
    input  pipe_ready, ld_ready, rf_we, rf_wR, rf_wD, ldq_empty
  );

endinterface

// File: rtl/wb_port_arbiter_ldq.sv
// Load-return circular FIFO of {kill, wR, wD}; head is combinational from the read pointer.
// A kill request marks every occupied entry with a matching index, plus the entry pushed this cycle.
module wb_ldq
  import wb_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = WBARB_LDQ_DEPTH,
  parameter  int DW    = RF_DW,
  parameter  int AW    = RF_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_wr,
  input  logic [DW-1:0] push_wd,
  input  logic          pop,
  input  logic          kill_en,
  input  logic [AW-1:0] kill_idx,
  output logic          head_kill,
  output logic [AW-1:0] head_wr,
  output logic [DW-1:0] head_wd,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] kill_q;
  logic [AW-1:0]    wr_q [DEPTH];
  logic [DW-1:0]    wd_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] kill_hit;
  logic             push_kill;

  // An entry is occupied when its distance from the head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PW-1:0] off;
    assign off         = PW'(i) - rd_ptr;
    assign kill_hit[i] = kill_en && ({1'b0, off} < count_q) && (wr_q[i] == kill_idx);
  end

  assign push_kill = kill_en && (push_wr == kill_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) kill_q[i] <= push_kill;
        else if (kill_hit[i])           kill_q[i] <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wr_q[wr_ptr] <= push_wr;
      wd_q[wr_ptr] <= push_wd;
    end
  end

  assign head_kill = kill_q[rd_ptr];
  assign head_wr   = wr_q[rd_ptr];
  assign head_wd   = wd_q[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between pipe writeback and queued load returns; loads win unless the pipe starves.
// Registered RF outputs one cycle after a grant; pipe_ready/ld_ready are derived from registered state only.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int LDQ_DEPTH  = WBARB_LDQ_DEPTH,
  parameter int STARVE_LIM = WBARB_STARVE_LIM,
  parameter int DW         = RF_DW,
  parameter int AW         = RF_AW
) (
  input logic               cpu_clk,
  input logic               cpu_rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(LDQ_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] count;
  logic          head_kill;
  logic [AW-1:0] head_wr;
  logic [DW-1:0] head_wd;
  logic [SW-1:0] starve_cnt;
  logic          at_lim;
  logic          empty;
  logic          pipe_ready_c;
  logic          ld_ready_c;
  logic          push;
  logic          kill_en;
  grant_e        gnt;

  logic          rf_we_q;
  logic [AW-1:0] rf_wr_q;
  logic [DW-1:0] rf_wd_q;

  assign empty        = (count == '0);
  assign at_lim       = (starve_cnt == SW'(STARVE_LIM));
  assign pipe_ready_c = empty || at_lim;
  assign ld_ready_c   = (count < CW'(LDQ_DEPTH));
  // Loads to x0 are accepted but never occupy a slot.
  assign push         = bus.ld_valid && ld_ready_c && (bus.ld_wR != '0);

  always_comb begin
    gnt = GNT_NONE;
    if (!empty && !(bus.pipe_valid && at_lim)) gnt = GNT_LD;
    else if (bus.pipe_valid && pipe_ready_c)   gnt = GNT_PIPE;
  end

  assign kill_en = (gnt == GNT_PIPE) && (bus.pipe_wR != '0);

  wb_ldq #(
    .DEPTH (LDQ_DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ldq (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .push      (push),
    .push_wr   (bus.ld_wR),
    .push_wd   (bus.ld_wD),
    .pop       (gnt == GNT_LD),
    .kill_en   (kill_en),
    .kill_idx  (bus.pipe_wR),
    .head_kill (head_kill),
    .head_wr   (head_wr),
    .head_wd   (head_wd),
    .count     (count)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      starve_cnt <= '0;
    end else if ((gnt == GNT_PIPE) || !bus.pipe_valid) begin
      starve_cnt <= '0;
    end else if ((gnt == GNT_LD) && !at_lim) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A killed load still takes its write slot, but with the enable dropped.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      rf_wd_q <= '0;
    end else begin
      case (gnt)
        GNT_PIPE: begin
          rf_we_q <= (bus.pipe_wR != '0);
          rf_wr_q <= bus.pipe_wR;
          rf_wd_q <= bus.pipe_wD;
        end
        GNT_LD: begin
          rf_we_q <= !head_kill && (head_wr != '0);
          rf_wr_q <= head_wr;
          rf_wd_q <= head_wd;
        end
        default: rf_we_q <= 1'b0;
      endcase
    end
  end

  assign bus.pipe_ready = pipe_ready_c;
  assign bus.ld_ready   = ld_ready_c;
  assign bus.ldq_empty  = empty;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wR      = rf_wr_q;
  assign bus.rf_wD      = rf_wd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipe/load writes, starvation, kill, full/x0 and mid-run reset.
module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ready_cnt;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_valid = 1'b0;
    bus.pipe_wR    = '0;
    bus.pipe_wD    = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_wR      = '0;
    bus.ld_wD      = '0;
  endtask

  task automatic drive_pipe(input logic [4:0] wr, input logic [31:0] wd);
    bus.pipe_valid = 1'b1;
    bus.pipe_wR    = wr;
    bus.pipe_wD    = wd;
  endtask

  task automatic drive_ld(input logic [4:0] wr, input logic [31:0] wd);
    bus.ld_valid = 1'b1;
    bus.ld_wR    = wr;
    bus.ld_wD    = wd;
  endtask

  initial begin
    logic [4:0]  exp_wr [5];
    logic [31:0] exp_wd [5];
    exp_wr = '{5'd1, 5'd2, 5'd3, 5'd10, 5'd4};
    exp_wd = '{32'h101, 32'h102, 32'h103, 32'h5555, 32'h104};
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_rf_wR", 64'(bus.rf_wR), 64'd0);
    chk("rst_rf_wD", 64'(bus.rf_wD), 64'd0);
    chk("rst_ldq_empty", 64'(bus.ldq_empty), 64'd1);
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
    cyc();

    // Pipe only
    drive_pipe(5'd5, 32'h1234);
    #2 chk("t1_pipe_ready", 64'(bus.pipe_ready), 64'd1);
    cyc();
    idle();
    chk("t1_rf_we", 64'(bus.rf_we), 64'd1);
    chk("t1_rf_wR", 64'(bus.rf_wR), 64'd5);
    chk("t1_rf_wD", 64'(bus.rf_wD), 64'h1234);
    cyc();
    chk("t1_idle_we", 64'(bus.rf_we), 64'd0);
    chk("t1_hold_wR", 64'(bus.rf_wR), 64'd5);

    // Load only
    drive_ld(5'd7, 32'hDEAD);
    #2 chk("t2_ld_ready", 64'(bus.ld_ready), 64'd1);
    cyc();
    idle();
    #2 chk("t2_queued", 64'(bus.ldq_empty), 64'd0);
    chk("t2_no_write_yet", 64'(bus.rf_we), 64'd0);
    cyc();
    chk("t2_rf_we", 64'(bus.rf_we), 64'd1);
    chk("t2_rf_wR", 64'(bus.rf_wR), 64'd7);
    chk("t2_rf_wD", 64'(bus.rf_wD), 64'hDEAD);
    chk("t2_drained", 64'(bus.ldq_empty), 64'd1);

    // Starvation: expected grant order ld,ld,ld,pipe,ld
    drive_ld(5'd1, 32'h101);
    cyc();
    chk("t3_e0_we", 64'(bus.rf_we), 64'd0);
    ready_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      idle();
      if (k <= 3) drive_ld(5'(k + 1), 32'h101 + 32'(k));
      drive_pipe(5'd10, 32'h5555);
      #2;
      chk($sformatf("t3_pipe_ready_%0d", k), 64'(bus.pipe_ready), 64'(k == 4));
      if (bus.pipe_ready) ready_cnt++;
      cyc();
      chk($sformatf("t3_we_%0d", k), 64'(bus.rf_we), 64'd1);
      chk($sformatf("t3_wR_%0d", k), 64'(bus.rf_wR), 64'(exp_wr[k-1]));
      chk($sformatf("t3_wD_%0d", k), 64'(bus.rf_wD), 64'(exp_wd[k-1]));
      if (k == 4) chk("t3_starve_clr", 64'(dut.starve_cnt), 64'd0);
    end
    chk("t3_ready_once", 64'(ready_cnt), 64'd1);
    idle();
    cyc();
    chk("t3_empty", 64'(bus.ldq_empty), 64'd1);
    chk("t3_starve_end", 64'(dut.starve_cnt), 64'd0);

    // Kill: load and younger pipe write to x9 in the same cycle
    drive_ld(5'd9, 32'hAAAA);
    drive_pipe(5'd9, 32'hBBBB);
    #2 chk("t4_pipe_ready", 64'(bus.pipe_ready), 64'd1);
    cyc();
    idle();
    chk("t4_pipe_we", 64'(bus.rf_we), 64'd1);
    chk("t4_pipe_wR", 64'(bus.rf_wR), 64'd9);
    chk("t4_pipe_wD", 64'(bus.rf_wD), 64'hBBBB);
    chk("t4_queued", 64'(bus.ldq_empty), 64'd0);
    cyc();
    chk("t4_kill_we", 64'(bus.rf_we), 64'd0);
    chk("t4_kill_wR", 64'(bus.rf_wR), 64'd9);
    cyc();
    chk("t4_empty", 64'(bus.ldq_empty), 64'd1);

    // Full: one net enqueue per starvation window -> full after 13 cycles
    for (int n = 1; n <= 13; n++) begin
      idle();
      drive_pipe(5'd20, 32'(n));
      drive_ld(5'(n), 32'h200 + 32'(n));
      if (n == 13) #2 chk("t5_ready_before_full", 64'(bus.ld_ready), 64'd1);
      cyc();
    end
    chk("t5_last_pipe_we", 64'(bus.rf_we), 64'd1);
    chk("t5_last_pipe_wR", 64'(bus.rf_wR), 64'd20);
    chk("t5_last_pipe_wD", 64'(bus.rf_wD), 64'd13);
    idle();
    drive_ld(5'd31, 32'hBAD);
    #2 chk("t5_full", 64'(bus.ld_ready), 64'd0);
    cyc();
    idle();
    chk("t5_drain_we", 64'(bus.rf_we), 64'd1);
    chk("t5_drain_wR10", 64'(bus.rf_wR), 64'd10);
    chk("t5_drain_wD10", 64'(bus.rf_wD), 64'h20A);
    for (int m = 11; m <= 13; m++) begin
      cyc();
      chk($sformatf("t5_drain_wR%0d", m), 64'(bus.rf_wR), 64'(m));
    end
    cyc();
    chk("t5_no_5th", 64'(bus.rf_we), 64'd0);
    chk("t5_empty", 64'(bus.ldq_empty), 64'd1);

    // Writes to x0
    drive_pipe(5'd0, 32'h77);
    cyc();
    idle();
    chk("t5_x0_pipe_we", 64'(bus.rf_we), 64'd0);
    chk("t5_x0_pipe_wR", 64'(bus.rf_wR), 64'd0);
    drive_ld(5'd0, 32'h88);
    #2 chk("t5_x0_ld_ready", 64'(bus.ld_ready), 64'd1);
    cyc();
    idle();
    chk("t5_x0_ld_dropped", 64'(bus.ldq_empty), 64'd1);
    cyc();
    chk("t5_x0_ld_we", 64'(bus.rf_we), 64'd0);
    chk("t5_x0_hold_wD", 64'(bus.rf_wD), 64'h77);

    // Reset with three queued entries
    for (int n = 1; n <= 9; n++) begin
      idle();
      drive_pipe(5'd20, 32'(n));
      drive_ld(5'(n), 32'h300 + 32'(n));
      cyc();
    end
    idle();
    chk("t6_pre_queued", 64'(bus.ldq_empty), 64'd0);
    chk("t6_pre_we", 64'(bus.rf_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_we", 64'(bus.rf_we), 64'd0);
    chk("t6_rst_wR", 64'(bus.rf_wR), 64'd0);
    chk("t6_rst_empty", 64'(bus.ldq_empty), 64'd1);
    chk("t6_rst_ld_ready", 64'(bus.ld_ready), 64'd1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_post_we0", 64'(bus.rf_we), 64'd0);
    cyc();
    chk("t6_post_we1", 64'(bus.rf_we), 64'd0);
    chk("t6_post_empty", 64'(bus.ldq_empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
